alu_mc_unit: RTL and testbench

Multi-cycle ALU execution unit for the LEGv8 datapath. It is the responder side of the ALU operand/result interface. It accepts one operation per request handshake and computes single-cycle ops in one cycle. It performs 64-bit multiply with an iterative radix-2 shift-add engine and returns a registered result and zero flag through a response handshake. It sits between the decode/issue logic, which acts as initiator, and the writeback/branch logic, which consumes the response.

---
 rtl/alu_mc_unit.sv | 116 +++++++++++
 tb/tb_alu_mc_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc_unit.sv
// LEGv8 ALU responder: single-cycle ops answer 1 cycle after accept, mul after DATA_WIDTH+1 cycles.
// Accepts only in IDLE; holds result in DONE until resp_ready, so at most one op is in flight.
module alu_mc_unit #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic [2:0]            alu_operation,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic                  busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_PASS = 3'b101;
  localparam logic [2:0] OP_NOR  = 3'b110;

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

  logic [1:0]            r_state;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_zero;
  logic [DATA_WIDTH-1:0] r_mcand;
  logic [DATA_WIDTH-1:0] r_mplr;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [CNT_WIDTH-1:0]  r_cnt;

  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_alu_res;
  logic [DATA_WIDTH-1:0] w_acc_next;

  assign w_accept = req_valid && (r_state == S_IDLE);

  always_comb begin
    w_alu_res = '0;
    case (alu_operation)
      OP_ADD:  w_alu_res = a_in + b_in;
      OP_SUB:  w_alu_res = a_in - b_in;
      OP_AND:  w_alu_res = a_in & b_in;
      OP_OR:   w_alu_res = a_in | b_in;
      OP_PASS: w_alu_res = b_in;
      OP_NOR:  w_alu_res = ~(a_in | b_in);
      default: w_alu_res = '0;
    endcase
  end

  // One shift-add step per MUL cycle; the last step's sum is written straight to result.
  assign w_acc_next = r_acc + (r_mplr[0] ? r_mcand : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_mcand  <= '0;
      r_mplr   <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (alu_operation == OP_MUL) begin
              r_mcand <= a_in;
              r_mplr  <= b_in;
              r_acc   <= '0;
              r_cnt   <= '0;
              r_state <= S_MUL;
            end else begin
              r_result <= w_alu_res;
              r_zero   <= (w_alu_res == '0);
              r_state  <= S_DONE;
            end
          end
        end
        S_MUL: begin
          r_acc   <= w_acc_next;
          r_mcand <= {r_mcand[DATA_WIDTH-2:0], 1'b0};
          r_mplr  <= {1'b0, r_mplr[DATA_WIDTH-1:1]};
          r_cnt   <= r_cnt + CNT_WIDTH'(1);
          if (r_cnt == LAST_CNT) begin
            r_result <= w_acc_next;
            r_zero   <= (w_acc_next == '0);
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (resp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);
  assign result     = r_result;
  assign zero       = r_zero;

endmodule

// File: tb/tb_alu_mc_unit.sv
// Bench for alu_mc_unit: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_mc_unit;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [DW-1:0] a_in;
  logic [DW-1:0] b_in;
  logic [2:0]    alu_operation;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] result;
  logic          zero;
  logic          busy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  alu_mc_unit #(.DATA_WIDTH(DW), .CNT_WIDTH(6)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .a_in(a_in), .b_in(b_in), .alu_operation(alu_operation),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .result(result), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: what the unit must show, from the opcode table and latency rules.
  bit          m_inflight = 1'b0;
  bit          m_resp     = 1'b0;
  int          m_wait     = 0;
  logic [DW-1:0] m_pending = '0;
  logic [DW-1:0] m_result  = '0;
  bit          m_zero     = 1'b1;

  function automatic logic [DW-1:0] ref_op(input logic [2:0] op,
                                           input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    logic [DW-1:0] r;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a * b;
      3'd5: r = b;
      3'd6: r = ~(a | b);
      default: r = '0;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_inflight = 1'b0;
      m_resp     = 1'b0;
      m_result   = '0;
      m_zero     = 1'b1;
    end else if (m_resp) begin
      if (resp_ready) m_resp = 1'b0;
    end else if (m_inflight) begin
      m_wait = m_wait - 1;
      if (m_wait == 0) begin
        m_inflight = 1'b0;
        m_resp     = 1'b1;
        m_result   = m_pending;
        m_zero     = (m_pending == '0);
      end
    end else if (req_valid) begin
      if (alu_operation == 3'd4) begin
        m_inflight = 1'b1;
        m_wait     = DW;
        m_pending  = ref_op(alu_operation, a_in, b_in);
      end else begin
        m_resp   = 1'b1;
        m_result = ref_op(alu_operation, a_in, b_in);
        m_zero   = (m_result == '0);
      end
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_resp_valid", DW'(resp_valid), DW'(m_resp));
      chk("model_req_ready",  DW'(req_ready),  DW'(!m_resp && !m_inflight));
      chk("model_busy",       DW'(busy),       DW'(m_resp || m_inflight));
      chk("model_result",     result,          m_result);
      chk("model_zero",       DW'(zero),       DW'(m_zero));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Presents one op for a single accept edge, then waits for the response; lat counts the accept edge as 1.
  task automatic run_op(input string name, input logic [2:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [DW-1:0] exp_res,
                        input bit exp_zero, input int exp_lat);
    int lat;
    req_valid = 1'b1; alu_operation = op; a_in = a; b_in = b;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 200) begin
      tick();
      lat++;
    end
    chk({name, "_lat"},  DW'(lat), DW'(exp_lat));
    chk({name, "_res"},  result, exp_res);
    chk({name, "_zero"}, DW'(zero), DW'(exp_zero));
  endtask

  initial begin
    int lat;
    logic [DW-1:0] ones;
    ones = '1;
    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    a_in = '0; b_in = '0; alu_operation = 3'd0;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_req_ready",  DW'(req_ready),  DW'(1));
    chk("rst_resp_valid", DW'(resp_valid), DW'(0));
    chk("rst_result",     result,          DW'(0));
    chk("rst_zero",       DW'(zero),       DW'(1));
    chk("rst_busy",       DW'(busy),       DW'(0));

    // Add with immediate consume
    resp_ready = 1'b1;
    run_op("add", 3'd0, 64'd5, 64'd6, 64'd11, 1'b0, 1);
    tick();
    chk("add_ready_after", DW'(req_ready), DW'(1));

    // Multiply latency and busy window
    req_valid = 1'b1; alu_operation = 3'd4; a_in = 64'd8; b_in = 64'd7;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 200) begin
      chk("mul_busy",      DW'(busy),      DW'(1));
      chk("mul_req_ready", DW'(req_ready), DW'(0));
      tick();
      lat++;
    end
    chk("mul_lat", DW'(lat), DW'(65));
    chk("mul_res", result, 64'd56);
    chk("mul_zero", DW'(zero), DW'(0));
    tick();

    // Zero flag and wraparound
    run_op("sub_zero", 3'd1, 64'd9, 64'd9, 64'd0, 1'b1, 1);
    tick();
    run_op("add_wrap", 3'd0, ones, 64'd1, 64'd0, 1'b1, 1);
    tick();
    run_op("rsvd", 3'd7, 64'd3, 64'd4, 64'd0, 1'b1, 1);
    tick();

    // Backpressure with a competing request during the stall
    resp_ready = 1'b0;
    run_op("bp", 3'd0, 64'd2, 64'd3, 64'd5, 1'b0, 1);
    req_valid = 1'b1; alu_operation = 3'd0; a_in = 64'd100; b_in = 64'd200;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", DW'(resp_valid), DW'(1));
      chk("bp_hold_res",   result,          64'd5);
      chk("bp_no_accept",  DW'(req_ready),  DW'(0));
    end
    resp_ready = 1'b1;
    tick();
    chk("bp_release_idle", DW'(req_ready), DW'(1));
    tick();
    req_valid = 1'b0;
    chk("bp_next_valid", DW'(resp_valid), DW'(1));
    chk("bp_next_res",   result,          64'd300);
    tick();

    // Reset in the middle of a multiply
    req_valid = 1'b1; alu_operation = 3'd4; a_in = 64'h1234; b_in = 64'h10;
    tick();
    req_valid = 1'b0;
    for (int i = 1; i < 30; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_resp_valid", DW'(resp_valid), DW'(0));
    chk("mrst_req_ready",  DW'(req_ready),  DW'(1));
    chk("mrst_result",     result,          DW'(0));
    chk("mrst_zero",       DW'(zero),       DW'(1));
    chk("mrst_busy",       DW'(busy),       DW'(0));
    for (int i = 0; i < 70; i++) begin
      tick();
      chk("mrst_no_resp", DW'(resp_valid), DW'(0));
    end
    run_op("mrst_add", 3'd0, 64'd2, 64'd3, 64'd5, 1'b0, 1);
    tick();

    // Multiply overflow with operands changing after accept
    req_valid = 1'b1; alu_operation = 3'd4; a_in = ones; b_in = 64'd2;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 200) begin
      a_in = {$urandom, $urandom};
      b_in = {$urandom, $urandom};
      alu_operation = 3'($urandom);
      tick();
      lat++;
    end
    chk("movf_lat", DW'(lat), DW'(65));
    chk("movf_res", result, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("movf_zero", DW'(zero), DW'(0));
    tick();

    // Randomized traffic, checked cycle by cycle against the model
    for (int i = 0; i < 1500; i++) begin
      req_valid     = ($urandom_range(0, 2) != 0);
      resp_ready    = ($urandom_range(0, 3) != 0);
      alu_operation = 3'($urandom);
      case ($urandom_range(0, 3))
        0: begin a_in = DW'($urandom_range(0, 15)); b_in = DW'($urandom_range(0, 15)); end
        1: begin a_in = {$urandom, $urandom}; b_in = a_in; end
        default: begin a_in = {$urandom, $urandom}; b_in = {$urandom, $urandom}; end
      endcase
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0;
    req_valid = 1'b0;
    tick();
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
